// File: rtl/lcd_nibble_writer_pkg.sv
// Shared definitions for the LCD nibble writer: FSM state encoding, controller
// command bytes and small helpers used by the top level.
package lcd_nibble_writer_pkg;

    typedef enum logic [3:0] {
        ST_POWERUP,
        ST_INIT_SETUP,
        ST_INIT_PULSE,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SETUP_HI,
        ST_PULSE_HI,
        ST_GAP,
        ST_SETUP_LO,
        ST_PULSE_LO,
        ST_WAIT
    } state_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;

    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_ENTRY;
            2'd2:    return LCD_DISP_ON;
            default: return LCD_CLEAR;
        endcase
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction

    function automatic int max_delay(input int a, input int b, input int c, input int d,
                                     input int e, input int f, input int g, input int h);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        if (f > m) m = f;
        if (g > m) m = g;
        if (h > m) m = h;
        return m;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter: iLoad takes (duration-1); oDone is high while the count is 0.
module lcd_delay_timer #(
    parameter int P_WIDTH     = 20,
    parameter int P_RESET_VAL = 0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iLoad,
    input  logic [P_WIDTH-1:0] iValue,
    output logic               oDone
);

    logic [P_WIDTH-1:0] r_count;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_count <= P_WIDTH'(P_RESET_VAL);
        end else if (iLoad) begin
            r_count <= iValue;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign oDone = (r_count == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Spartan-3E character LCD writer in 4-bit mode: runs power-on init and
// configuration, then sends accepted bytes as two timed nibbles.
module lcd_nibble_writer
    import lcd_nibble_writer_pkg::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_INIT_1  = 205000,
    parameter int T_INIT_2  = 5000,
    parameter int T_SETUP   = 2,
    parameter int T_PULSE   = 12,
    parameter int T_GAP     = 50,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWrite,
    input  logic       iRS,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic       oInitDone,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    localparam int P_MAX_DELAY = max_delay(T_POWERUP, T_INIT_1, T_INIT_2, T_SETUP,
                                           T_PULSE, T_GAP, T_CMD, T_CLEAR);
    localparam int P_TIMER_W   = $clog2(P_MAX_DELAY) + 1;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_timer_done;
    logic                   w_load;
    int                     w_dur;
    logic [P_TIMER_W-1:0]   w_load_value;

    logic                   w_accept;
    logic                   w_init_step;
    logic                   w_cfg_start;
    logic                   w_cfg_step;
    logic                   w_cfg_finish;

    logic [7:0]             r_byte;
    logic                   r_rs;
    logic [1:0]             r_init_idx;
    logic [1:0]             r_cfg_idx;
    logic                   r_cfg_active;
    logic                   r_init_done;
    logic                   r_lcd_e;
    logic                   r_lcd_rs;
    logic [3:0]             r_lcd_data;

    assign w_load_value = P_TIMER_W'(w_dur - 1);

    lcd_delay_timer #(
        .P_WIDTH     (P_TIMER_W),
        .P_RESET_VAL (T_POWERUP - 1)
    ) u_timer (
        .Clock  (Clock),
        .Reset  (Reset),
        .iLoad  (w_load),
        .iValue (w_load_value),
        .oDone  (w_timer_done)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= ST_POWERUP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Each transition reloads the timer with the length of the state being entered.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches are inferred.
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dur        = 1;
        w_accept     = 1'b0;
        w_init_step  = 1'b0;
        w_cfg_start  = 1'b0;
        w_cfg_step   = 1'b0;
        w_cfg_finish = 1'b0;

        case (r_state)
            ST_POWERUP: begin
                if (w_timer_done) begin
                    w_next_state = ST_INIT_SETUP;
                    w_load       = 1'b1;
                    w_dur        = T_SETUP;
                end
            end
            ST_INIT_SETUP: begin
                if (w_timer_done) begin
                    w_next_state = ST_INIT_PULSE;
                    w_load       = 1'b1;
                    w_dur        = T_PULSE;
                end
            end
            ST_INIT_PULSE: begin
                if (w_timer_done) begin
                    w_next_state = ST_INIT_WAIT;
                    w_load       = 1'b1;
                    w_dur        = (r_init_idx == 2'd0) ? T_INIT_1 :
                                   (r_init_idx == 2'd1) ? T_INIT_2 : T_CMD;
                end
            end
            ST_INIT_WAIT: begin
                if (w_timer_done) begin
                    w_load = 1'b1;
                    w_dur  = T_SETUP;
                    if (r_init_idx == 2'd3) begin
                        w_next_state = ST_SETUP_HI;
                        w_cfg_start  = 1'b1;
                    end else begin
                        w_next_state = ST_INIT_SETUP;
                        w_init_step  = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (iWrite && r_init_done) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_SETUP_HI;
                    w_load       = 1'b1;
                    w_dur        = T_SETUP;
                end
            end
            ST_SETUP_HI: begin
                if (w_timer_done) begin
                    w_next_state = ST_PULSE_HI;
                    w_load       = 1'b1;
                    w_dur        = T_PULSE;
                end
            end
            ST_PULSE_HI: begin
                if (w_timer_done) begin
                    w_next_state = ST_GAP;
                    w_load       = 1'b1;
                    w_dur        = T_GAP;
                end
            end
            ST_GAP: begin
                if (w_timer_done) begin
                    w_next_state = ST_SETUP_LO;
                    w_load       = 1'b1;
                    w_dur        = T_SETUP;
                end
            end
            ST_SETUP_LO: begin
                if (w_timer_done) begin
                    w_next_state = ST_PULSE_LO;
                    w_load       = 1'b1;
                    w_dur        = T_PULSE;
                end
            end
            ST_PULSE_LO: begin
                if (w_timer_done) begin
                    w_next_state = ST_WAIT;
                    w_load       = 1'b1;
                    w_dur        = is_slow_cmd(r_rs, r_byte) ? T_CLEAR : T_CMD;
                end
            end
            ST_WAIT: begin
                if (w_timer_done) begin
                    if (r_cfg_active && r_cfg_idx != 2'd3) begin
                        w_next_state = ST_SETUP_HI;
                        w_load       = 1'b1;
                        w_dur        = T_SETUP;
                        w_cfg_step   = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_cfg_finish = r_cfg_active;
                    end
                end
            end
            default: begin
                w_next_state = ST_POWERUP;
            end
        endcase
    end

    // Pin drivers are registered from the current state, so they lag the state by one cycle.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_byte       <= 8'h00;
            r_rs         <= 1'b0;
            r_init_idx   <= 2'd0;
            r_cfg_idx    <= 2'd0;
            r_cfg_active <= 1'b0;
            r_init_done  <= 1'b0;
            r_lcd_e      <= 1'b0;
            r_lcd_rs     <= 1'b0;
            r_lcd_data   <= 4'h0;
        end else begin
            if (w_accept) begin
                r_byte <= iData;
                r_rs   <= iRS;
            end else if (w_cfg_start) begin
                r_byte       <= cfg_byte(2'd0);
                r_rs         <= 1'b0;
                r_cfg_active <= 1'b1;
                r_cfg_idx    <= 2'd0;
            end else if (w_cfg_step) begin
                r_byte    <= cfg_byte(r_cfg_idx + 2'd1);
                r_cfg_idx <= r_cfg_idx + 2'd1;
            end

            if (w_init_step) begin
                r_init_idx <= r_init_idx + 2'd1;
            end
            if (w_cfg_finish) begin
                r_cfg_active <= 1'b0;
                r_init_done  <= 1'b1;
            end

            r_lcd_e <= (r_state == ST_INIT_PULSE) || (r_state == ST_PULSE_HI) ||
                       (r_state == ST_PULSE_LO);

            case (r_state)
                ST_INIT_SETUP, ST_INIT_PULSE, ST_INIT_WAIT: begin
                    r_lcd_rs   <= 1'b0;
                    r_lcd_data <= (r_init_idx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
                end
                ST_SETUP_HI, ST_PULSE_HI, ST_GAP: begin
                    r_lcd_rs   <= r_rs;
                    r_lcd_data <= r_byte[7:4];
                end
                ST_SETUP_LO, ST_PULSE_LO, ST_WAIT: begin
                    r_lcd_rs   <= r_rs;
                    r_lcd_data <= r_byte[3:0];
                end
                default: begin
                    r_lcd_rs   <= r_lcd_rs;
                    r_lcd_data <= r_lcd_data;
                end
            endcase
        end
    end

    assign oReady    = (r_state == ST_IDLE) && r_init_done;
    assign oInitDone = r_init_done;
    assign oLCD_E    = r_lcd_e;
    assign oLCD_RS   = r_lcd_rs;
    assign oLCD_RW   = 1'b0;
    assign oLCD_Data = r_lcd_data;

endmodule

// File: doc/lcd_nibble_writer.md
# lcd_nibble_writer

Responder side of the CPU's `LCD` instruction. It accepts one byte per request plus a register-select bit from the core's execute stage and drives the Spartan-3E character LCD in 4-bit mode (SF_D[11:8], LCD_E, LCD_RS, LCD_RW). It performs the power-on initialization and configuration sequence by itself, then strobes each byte as two nibbles with the controller's setup, pulse and execution delays. It reports `oReady` so the ROM program no longer needs `NOP` delay padding.

## Interface
Parameters (all in `Clock` cycles, 50 MHz defaults):
- `T_POWERUP`, 750000: 15 ms power-on wait.
- `T_INIT_1`, 205000: 4.1 ms after the first 0x3 nibble.
- `T_INIT_2`, 5000: 100 µs after the second 0x3 nibble.
- `T_SETUP`, 2: RS/data setup before E rises.
- `T_PULSE`, 12: E high width.
- `T_GAP`, 50: 1 µs between the upper and lower nibble.
- `T_CMD`, 2000: 40 µs execution wait for a normal byte, and after init nibbles 3 and 4.
- `T_CLEAR`, 82000: 1.64 ms wait after clear/home.

Ports:
- `Clock` in 1: single clock.
- `Reset` in 1: synchronous, active-low.
- `iWrite` in 1: request strobe.
- `iRS` in 1: 0 = command, 1 = character data.
- `iData` in 8: byte to send.
- `oReady` out 1: block idle and able to accept.
- `oInitDone` out 1: sticky high once configuration completes.
- `oLCD_E` out 1: LCD enable strobe.
- `oLCD_RS` out 1: LCD register select.
- `oLCD_RW` out 1: tied 0 (write only).
- `oLCD_Data` out 4: SF_D[11:8].

## Operation
- **Reset (`Reset`=0 at an edge):**
  - All outputs go to 0 and the FSM goes to POWERUP.
  - A reset during any state aborts the transfer, so E falls at that edge.
- **FSM states:** POWERUP → INIT_NIB → CFG → IDLE, with a byte sequence SETUP_HI → PULSE_HI → GAP → SETUP_LO → PULSE_LO → WAIT → IDLE.
- **INIT_NIB:**
  - Sends nibbles 0x3, 0x3, 0x3, 0x2 with RS=0. Each nibble is T_SETUP cycles with E=0, then T_PULSE cycles with E=1.
  - The waits that follow are T_INIT_1, T_INIT_2, T_CMD and T_CMD respectively.
- **CFG:**
  - Sends bytes 0x28, 0x06, 0x0C, 0x01 through the normal byte sequence with RS=0.
  - After the last byte's wait, `oInitDone`=1 and the FSM enters IDLE.
- **IDLE:**
  - `oReady`=1 only in IDLE with `oInitDone`=1.
  - When `iWrite`=1 and `oReady`=1 at an edge, the block latches `iRS` and `iData` and drops `oReady` at that same edge.
  - `iWrite` while `oReady`=0 is ignored; it is not queued.
- **Byte sequence:**
  - The upper nibble goes out first, then the lower nibble.
  - `oLCD_Data` and `oLCD_RS` stay constant from the start of SETUP through the end of the following GAP/WAIT.
- **WAIT length:**
  - T_CLEAR when the latched RS=0 and the latched byte is 0x01, 0x02 or 0x03.
  - T_CMD otherwise.
- **Timer:** a single down-counter whose width is `$clog2` of the largest parameter plus 1. It reloads with (value−1) on each state entry and the state advances when it reaches 0.

## Timing
- **Accept to E rise:** if acceptance happens at edge k, the upper nibble is on `oLCD_Data` from edge k+1 and E rises at edge k+1+T_SETUP.
- **Full byte:** `oReady` returns high 2·(T_SETUP+T_PULSE)+T_GAP+T_WAIT cycles after edge k.
- **Back-to-back:** `iWrite` held high continuously is accepted on the first cycle `oReady`=1. There is no bubble beyond the WAIT time.
- **Init duration:** T_POWERUP + 4·(T_SETUP+T_PULSE) + T_INIT_1 + T_INIT_2 + 2·T_CMD, plus the CFG bytes (three normal byte waits and one T_CLEAR wait).
- **E protection:** E is never high during a reset cycle or in any state other than PULSE_*.

## Structure
- **Shared definitions file:** shared constants go in the codebase's definitions include (`Defintions.v`). These are the FSM state encodings and the LCD command constants (`LCD_FUNC_SET` 8'h28, `LCD_ENTRY` 8'h06, `LCD_DISP_ON` 8'h0C, `LCD_CLEAR` 8'h01).
- **Sub-module `lcd_delay_timer`:** a parameterized loadable down-counter with a `oDone` flag.
- **Top level:** the FSM and nibble mux stay in the top module.

## Test plan
All scenarios use shrunken parameters: T_POWERUP=20, T_INIT_1=10, T_INIT_2=6, T_SETUP=2, T_PULSE=3, T_GAP=4, T_CMD=8, T_CLEAR=15.
- **Reset and init:** hold `Reset`=0 for 3 cycles, then release → all outputs 0 during reset.
  - E pulses appear with `oLCD_Data` 3,3,3,2, then 2,8,0,6,0,C,0,1, each pulse exactly 3 cycles wide.
  - `oInitDone` rises after the 0x01 byte's 15-cycle wait.
- **Data byte:** `iWrite`=1, `iRS`=1, `iData`=0x48 → RS=1; nibble 4 then nibble 8; `oReady` back high 2·(2+3)+4+8 = 22 cycles after acceptance.
- **Clear command:** `iRS`=0, `iData`=0x01 → `oReady` back high after 2·5+4+15 = 29 cycles.
- **Busy write:** a second `iWrite` (`iData`=0x55) pulsed while `oReady`=0 → no extra E pulses; the next byte shows only the first data.
- **Reset mid-byte:** assert `Reset` during PULSE_HI → E=0 at the next edge; the full init sequence restarts and `oInitDone`=0.
- **Continuous write:** `iWrite` held high with data 0x41, 0x42 → exactly two transfers, each accepted on the first `oReady` cycle.
